adc_scan_ctrl: RTL and testbench

Parametrised SPI scan controller for the board's 8-input, 12-bit serial ADC (ADC128S022-style protocol). It succeeds the fixed 8-channel controller: one system clock with an internally divided SCLK instead of a clock pair, a runtime channel-enable mask, and single-shot or continuous scan modes. It handles the ADC's one-frame result pipeline and outputs a per-sample strobe plus a packed per-channel result register.

---
 rtl/adc_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_ctrl
// Purpose  : SPI scan controller for an 8-input, 12-bit serial ADC
//            (ADC128S022-style). The block divides the system clock down to
//            SCLK and walks the enabled channels in ascending order. It
//            accounts for the ADC's one-frame result latency and publishes
//            each result as a strobe and into a packed per-channel register.
//            Single-shot and continuous scan modes are supported.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   iCLK          in   1          system clock
//   iRST          in   1          asynchronous active-high reset
//   iGO           in   1          start request, honoured only when idle
//   iCONT         in   1          continuous mode (start and each scan end)
//   iCH_EN        in   NUM_CH     channel enable mask, latched on start
//   oCS           out  1          ADC chip select, active low
//   oSCLK         out  1          ADC serial clock, idles high
//   oDIN          out  1          command bit to ADC
//   iDOUT         in   1          data bit from ADC
//   oBUSY         out  1          high from accepted start until idle
//   oSAMPLE_STB   out  1          one-clock pulse, new result valid
//   oSAMPLE_CH    out  3          channel of the strobed result
//   oSAMPLE_DATA  out  12         strobed result
//   oSCAN_DONE    out  1          pulse when highest enabled channel stored
//   oADC_DATA     out  NUM_CH*12  latest result per channel, ch n at [n*12+:12]
// ============================================================================
module adc_scan_ctrl #(
  parameter int NUM_CH   = 8,
  parameter int SCLK_DIV = 2,
  parameter int GAP_HP   = 2
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iGO,
  input  logic                   iCONT,
  input  logic [NUM_CH-1:0]      iCH_EN,
  output logic                   oCS,
  output logic                   oSCLK,
  output logic                   oDIN,
  input  logic                   iDOUT,
  output logic                   oBUSY,
  output logic                   oSAMPLE_STB,
  output logic [2:0]             oSAMPLE_CH,
  output logic [11:0]            oSAMPLE_DATA,
  output logic                   oSCAN_DONE,
  output logic [NUM_CH*12-1:0]   oADC_DATA
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int HP_W  = ($clog2(GAP_HP) > 5) ? $clog2(GAP_HP) + 1 : 6;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [HP_W-1:0]  SHIFT_LAST = HP_W'(31);
  localparam logic [HP_W-1:0]  GAP_LAST   = HP_W'(GAP_HP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // Lowest set bit of a mask (0 if empty).
  function automatic logic [2:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  // Highest set bit of a mask (0 if empty).
  function automatic logic [2:0] highest(input logic [NUM_CH-1:0] m);
    highest = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m[i]) highest = 3'(i);
    end
  endfunction

  // {found, channel}: smallest enabled channel strictly above a.
  function automatic logic [3:0] next_above(input logic [NUM_CH-1:0] m,
                                            input logic [2:0] a);
    next_above = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (3'(i) > a)) next_above = {1'b1, 3'(i)};
    end
  endfunction

  state_t              state, next_state;
  logic [DIV_W-1:0]    div_cnt;
  logic [HP_W-1:0]     hp_cnt;
  logic                tick;
  logic                start, setup_end, shift_end, gap_end;

  logic                sclk, din;
  logic [15:0]         cmd_sr;
  // Only the last 12 of the 16 shifted bits form the result, so the
  // leading zero bits are simply shifted out of a 12-bit register.
  logic [11:0]         shreg;
  logic [NUM_CH-1:0]   mask;
  logic                cont;
  logic [2:0]          cur_addr;
  logic                cur_real;
  logic [2:0]          prev_addr;
  logic                pending;
  logic                sample_stb;
  logic [2:0]          sample_ch;
  logic [11:0]         sample_data;
  logic                scan_done;
  logic [NUM_CH*12-1:0] adc_data;

  logic [2:0]          low_ch, high_ch, start_ch;
  logic [3:0]          nxt;

  assign low_ch   = lowest(mask);
  assign high_ch  = highest(mask);
  assign start_ch = lowest(iCH_EN);
  assign nxt      = next_above(mask, cur_addr);

  assign tick = (state != S_IDLE) && (div_cnt == DIV_LAST);

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state and phase-event decode
  always_comb begin
    next_state = state;
    start      = 1'b0;
    setup_end  = 1'b0;
    shift_end  = 1'b0;
    gap_end    = 1'b0;
    case (state)
      S_IDLE: begin
        if (iGO && (|iCH_EN)) begin
          start      = 1'b1;
          next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          setup_end  = 1'b1;
          next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick && (hp_cnt == SHIFT_LAST)) begin
          shift_end  = 1'b1;
          next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (tick && (hp_cnt == GAP_LAST)) begin
          gap_end    = 1'b1;
          // A real frame always leaves a result pending, so another frame
          // (next channel, wrap or flush) follows; after a flush we stop.
          next_state = pending ? S_SETUP : S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_cnt     <= '0;
      hp_cnt      <= '0;
      sclk        <= 1'b1;
      din         <= 1'b0;
      cmd_sr      <= '0;
      shreg       <= '0;
      mask        <= '0;
      cont        <= 1'b0;
      cur_addr    <= '0;
      cur_real    <= 1'b0;
      prev_addr   <= '0;
      pending     <= 1'b0;
      sample_stb  <= 1'b0;
      sample_ch   <= '0;
      sample_data <= '0;
      scan_done   <= 1'b0;
      adc_data    <= '0;
    end else begin
      sample_stb <= 1'b0;
      scan_done  <= 1'b0;

      if ((state == S_IDLE) || tick) div_cnt <= '0;
      else                           div_cnt <= div_cnt + 1'b1;

      // Half-period counter restarts at every phase change.
      if (state != next_state) hp_cnt <= '0;
      else if (tick)           hp_cnt <= hp_cnt + 1'b1;

      if (start) begin
        mask     <= iCH_EN;
        cont     <= iCONT;
        cur_addr <= start_ch;
        cur_real <= 1'b1;
        pending  <= 1'b0;
      end

      // First falling SCLK edge presents command bit 15.
      if (setup_end) begin
        sclk   <= 1'b0;
        din    <= 1'b0;
        cmd_sr <= {1'b0, cur_addr, 12'd0};
      end

      // Even half-period index ends with a rising edge (sample), odd
      // index ends with a falling edge (next command bit).
      if ((state == S_SHIFT) && tick && !shift_end) begin
        if (!hp_cnt[0]) begin
          sclk  <= 1'b1;
          shreg <= {shreg[10:0], iDOUT};
        end else begin
          sclk   <= 1'b0;
          din    <= cmd_sr[15];
          cmd_sr <= {cmd_sr[14:0], 1'b0};
        end
      end

      // The data clocked in during this frame answers the previous address.
      if (shift_end) begin
        din <= 1'b0;
        if (pending) begin
          sample_stb  <= 1'b1;
          sample_ch   <= prev_addr;
          sample_data <= shreg;
          scan_done   <= (prev_addr == high_ch);
          for (int n = 0; n < NUM_CH; n++) begin
            if (prev_addr == 3'(n)) adc_data[n*12 +: 12] <= shreg;
          end
        end
        pending   <= cur_real;
        prev_addr <= cur_addr;
      end

      if (gap_end && pending) begin
        if (nxt[3]) begin
          cur_addr <= nxt[2:0];
          cur_real <= 1'b1;
        end else if (cont && iCONT) begin
          cur_addr <= low_ch;
          cur_real <= 1'b1;
        end else begin
          // Flush frame: only collects the last result.
          cur_addr <= low_ch;
          cur_real <= 1'b0;
          cont     <= 1'b0;
        end
      end
    end
  end

  assign oCS          = !((state == S_SETUP) || (state == S_SHIFT));
  assign oSCLK        = sclk;
  assign oDIN         = din;
  assign oBUSY        = (state != S_IDLE);
  assign oSAMPLE_STB  = sample_stb;
  assign oSAMPLE_CH   = sample_ch;
  assign oSAMPLE_DATA = sample_data;
  assign oSCAN_DONE   = scan_done;
  assign oADC_DATA    = adc_data;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_scan_ctrl
// Purpose  : Self-checking bench for adc_scan_ctrl. A behavioural ADC answers
//            each frame with the value of the channel addressed in the
//            previous frame. Expected frame addresses and result strobes are
//            queued from the channel mask when a scan is launched. Monitors
//            pop and compare them as the DUT produces frames and strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_scan_ctrl;

  localparam int NUM_CH     = 8;
  localparam int SCLK_DIV   = 3;
  localparam int GAP_HP     = 2;
  localparam int FRAME_CLKS = (33 + GAP_HP) * SCLK_DIV;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
    logic        done;
  } stb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        cont = 1'b0;
  logic [7:0]  ch_en = 8'd0;
  logic        dout = 1'b0;
  logic        cs, sclk, din, busy, stb, scan_done;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;
  logic [95:0] adc_data;

  always #5 clk = ~clk;

  adc_scan_ctrl #(
    .NUM_CH(NUM_CH), .SCLK_DIV(SCLK_DIV), .GAP_HP(GAP_HP)
  ) dut (
    .iCLK(clk), .iRST(rst), .iGO(go), .iCONT(cont), .iCH_EN(ch_en),
    .oCS(cs), .oSCLK(sclk), .oDIN(din), .iDOUT(dout), .oBUSY(busy),
    .oSAMPLE_STB(stb), .oSAMPLE_CH(sample_ch), .oSAMPLE_DATA(sample_data),
    .oSCAN_DONE(scan_done), .oADC_DATA(adc_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mon_off = 1'b0;

  logic [11:0] adc_val [8];
  logic [95:0] exp_adc = '0;
  stb_t        stb_q[$];
  logic [2:0]  frame_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event-missing expected event-present", name);
  endtask

  always @(negedge clk) cyc++;

  // Result-strobe monitor
  stb_t mon_e;
  always @(negedge clk) begin
    if (!mon_off) begin
      if (stb) begin
        if (stb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got ch %0d expected no strobe", sample_ch);
        end else begin
          mon_e = stb_q.pop_front();
          chk("sample_ch", 96'(sample_ch), 96'(mon_e.ch));
          chk("sample_data", 96'(sample_data), 96'(mon_e.data));
          chk("scan_done", 96'(scan_done), 96'(mon_e.done));
          chk("adc_data_slot", 96'(adc_data[int'(sample_ch)*12 +: 12]), 96'(mon_e.data));
        end
      end else if (scan_done) begin
        chk("done_without_strobe", 96'(scan_done), 96'(0));
      end
    end
  end

  // Behavioural ADC and SPI framing monitor
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0;
  logic        gap_valid = 1'b0, din_ok = 1'b1;
  int          rises = 0, low_len = 0, high_len = 0, bitk = 0;
  logic [15:0] rx = '0, tx = '0;
  logic [2:0]  exp_addr;
  always @(negedge clk) begin
    if (mon_off) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b1;
      gap_valid = 1'b0;
    end else begin
      if (prev_cs && !cs) begin
        if (gap_valid) chk("cs_high_gap", 96'(high_len), 96'(GAP_HP * SCLK_DIV));
        rises = 0; low_len = 0; rx = '0; din_ok = 1'b1; bitk = 0;
      end
      if (!cs) begin
        low_len++;
        if (prev_sclk && !sclk) begin
          if (bitk < 16) dout = tx[15 - bitk];
          bitk++;
        end
        if (!prev_sclk && sclk) begin
          rises++;
          rx = {rx[14:0], din};
          if (din !== prev_din) din_ok = 1'b0;
        end
      end
      if (!prev_cs && cs) begin
        chk("sclk_rises", 96'(rises), 96'(16));
        chk("din_stable", 96'(din_ok), 96'(1));
        chk("cs_low_len", 96'(low_len), 96'(33 * SCLK_DIV));
        if (frame_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: got addr %0d expected no frame", rx[13:11]);
        end else begin
          exp_addr = frame_q.pop_front();
          chk("frame_addr", 96'(rx[13:11]), 96'(exp_addr));
        end
        tx = {4'h0, adc_val[rx[13:11]]};
        high_len = 0;
        gap_valid = 1'b1;
      end
      if (cs) high_len++;
      if (!busy) gap_valid = 1'b0;
      prev_cs   = cs;
      prev_sclk = sclk;
      prev_din  = din;
    end
  end

  // Launch one run. drop_after < 0: single scan. Otherwise continuous, with
  // iCONT dropped right after drop_after scan_done pulses.
  task automatic run_scan(input logic [7:0] mask, input int drop_after,
                          input bit poke, input bit fixed_data);
    int   en[$];
    int   m, nscans, nframes, waited, dones, c0;
    stb_t e;
    for (int c = 0; c < 8; c++)
      adc_val[c] = fixed_data ? 12'(12'h100 + c) : 12'($urandom);
    for (int c = 0; c < 8; c++) if (mask[c]) en.push_back(c);
    m = en.size();
    nscans  = (drop_after < 0) ? 1 : drop_after + 1;
    nframes = nscans * m + 1;
    for (int s = 0; s < nscans; s++) begin
      for (int j = 0; j < m; j++) begin
        frame_q.push_back(3'(en[j]));
        e.ch = 3'(en[j]);
        e.data = adc_val[en[j]];
        e.done = (j == m - 1);
        stb_q.push_back(e);
      end
    end
    frame_q.push_back(3'(en[0]));

    @(negedge clk);
    ch_en = mask;
    cont  = (drop_after >= 0);
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    c0 = cyc;
    chk("busy_after_go", 96'(busy), 96'(1));

    if (drop_after >= 0) begin
      dones = 0;
      waited = 0;
      while (dones < drop_after && waited < nframes * FRAME_CLKS) begin
        @(negedge clk);
        waited++;
        if (scan_done) dones++;
      end
      if (dones < drop_after) fail_now("cont_done_timeout");
      cont = 1'b0;
    end

    if (poke) begin
      repeat (FRAME_CLKS + 20) @(negedge clk);
      chk("busy_at_poke", 96'(busy), 96'(1));
      ch_en = ~mask;
      go = 1'b1;
      repeat (3) @(negedge clk);
      go = 1'b0;
      ch_en = mask;
    end

    waited = 0;
    while (busy && waited < nframes * FRAME_CLKS + 50) begin
      @(negedge clk);
      waited++;
    end
    if (busy) fail_now("busy_timeout");
    chk("run_length", 96'(cyc - c0), 96'(nframes * FRAME_CLKS));
    chk("strobes_left", 96'(stb_q.size()), 96'(0));
    chk("frames_left", 96'(frame_q.size()), 96'(0));
    stb_q.delete();
    frame_q.delete();
    for (int j = 0; j < m; j++) exp_adc[en[j]*12 +: 12] = adc_val[en[j]];
    chk("adc_data_all", adc_data, exp_adc);
    chk("cs_idle", 96'(cs), 96'(1));
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic any_cs_low, any_busy;
    for (int c = 0; c < 8; c++) adc_val[c] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 96'(cs), 96'(1));
    chk("rst_sclk", 96'(sclk), 96'(1));
    chk("rst_din", 96'(din), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_stb", 96'(stb), 96'(0));
    chk("rst_adc_data", adc_data, 96'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Fixed scan: channels 0 and 2, ADC answers 12'h100 + address.
    run_scan(8'h05, -1, 1'b0, 1'b1);
    chk("ch2_slot", 96'(adc_data[35:24]), 96'(12'h102));

    // Asynchronous reset in the middle of a shift phase.
    mon_off = 1'b1;
    @(negedge clk);
    ch_en = 8'($urandom_range(1, 255));
    cont = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (SCLK_DIV * 10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cs", 96'(cs), 96'(1));
    chk("arst_sclk", 96'(sclk), 96'(1));
    chk("arst_din", 96'(din), 96'(0));
    chk("arst_busy", 96'(busy), 96'(0));
    chk("arst_stb", 96'(stb), 96'(0));
    chk("arst_ch", 96'(sample_ch), 96'(0));
    chk("arst_data", 96'(sample_data), 96'(0));
    chk("arst_adc_data", adc_data, 96'(0));
    exp_adc = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", 96'(busy), 96'(0));
    chk("post_rst_cs", 96'(cs), 96'(1));
    mon_off = 1'b0;

    // Random single scans
    for (int t = 0; t < 5; t++) run_scan(8'($urandom_range(1, 255)), -1, 1'b0, 1'b0);

    // Continuous: all channels for three scans, then a random mask
    run_scan(8'hFF, 2, 1'b0, 1'b0);
    run_scan(8'($urandom_range(1, 255)), 1, 1'b0, 1'b0);

    // Continuous with a single channel
    run_scan(8'(8'h01 << $urandom_range(0, 7)), 3, 1'b0, 1'b0);

    // New start request with a different mask while busy
    run_scan(8'($urandom_range(1, 255)), -1, 1'b1, 1'b0);

    // Empty mask is ignored
    any_cs_low = 1'b0;
    any_busy = 1'b0;
    ch_en = 8'h00;
    go = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!cs) any_cs_low = 1'b1;
      if (busy) any_busy = 1'b1;
    end
    go = 1'b0;
    chk("empty_mask_cs", 96'(any_cs_low), 96'(0));
    chk("empty_mask_busy", 96'(any_busy), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
